ifu: RTL and testbench
======================

# ifu

Instruction fetch unit for the two-register processor. Reads the instruction memory, decodes control-flow opcodes locally, and issues datapath opcodes 0–11 to the execution unit controller over the `instr_valid`/`instr_done` handshake. It owns the program counter and sits between the instruction memory and the instruction decoder/EU controller.

## Interface
Parameters:
- `PC_W`, 8: program counter and instruction memory address width.
- `INSTR_W`, 8: instruction width. Opcode is in `[INSTR_W-1:INSTR_W-4]`. The operand/offset is in `[3:0]`.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start_i`  in  1: begin or resume fetching. Sampled only in IDLE and HALTED.
- `imem_rd_enb_o`  out  1: instruction memory read enable.
- `imem_addr_o`  out  PC_W: instruction memory address; always equals the PC.
- `imem_data_i`  in  INSTR_W: read data, valid one cycle after `imem_rd_enb_o`.
- `instr_o`  out  INSTR_W: registered instruction presented to the decoder.
- `instr_valid_o`  out  1: `instr_o` is valid and awaiting execution.
- `instr_done_i`  in  1: EU controller is in an execute state.
- `cmp_flag_i`  in  1: compare flag from the EU datapath.
- `halted_o`  out  1: the FSM is in HALTED.
- `pc_o`  out  PC_W: current PC, for debug.

## Operation
- Opcodes:
  - 0–11 are datapath instructions (LOAD, AND, STORE, ADD, ADI, CMPLT, CMPEQ, CMPEQI, SHFTR, SHFTL, INV, MVI). They are forwarded to the EU.
  - 12 BRT: branch if `cmp_flag_i`=1.
  - 13 BRF: branch if `cmp_flag_i`=0.
  - 14 NOP.
  - 15 HALT.
  - Opcodes 12–15 never reach the EU.
- States: IDLE, FETCH, DECODE, ISSUE, HALTED.
  - IDLE: on `start_i`, go to FETCH. Otherwise stay.
  - FETCH: `imem_rd_enb_o`=1, then go to DECODE.
  - DECODE: `imem_data_i` is valid this cycle.
    - Opcode 0–11: latch into `instr_o`, set `instr_valid_o`, go to ISSUE.
    - BRT/BRF taken: PC ← PC + sign_extend(`[3:0]`). Go to FETCH.
    - BRT/BRF not taken, or NOP: PC ← PC+1. Go to FETCH.
    - HALT: PC ← PC+1. Go to HALTED.
  - ISSUE: hold `instr_o` and `instr_valid_o`=1 until `instr_done_i`=1. Then, at that edge, clear `instr_valid_o`, PC ← PC+1, and go to FETCH.
  - HALTED: `halted_o`=1. On `start_i`, go to FETCH at the current PC, which is the address after the HALT.
- PC arithmetic:
  - Modulo 2^PC_W; increments and branches wrap silently.
  - Branch offset range is −8..+7 relative to the branch instruction's own address.
  - Offset 0 is a legal self-loop.
- `cmp_flag_i` is sampled in DECODE only. It is stable there because the EU is idle.
- `instr_done_i` seen outside ISSUE is ignored.
- `start_i` seen in FETCH, DECODE or ISSUE is ignored.
- Reset values: PC=0, state=IDLE, `instr_o`=0, `instr_valid_o`=0, `imem_rd_enb_o`=0, `halted_o`=0, `imem_addr_o`=`pc_o`=0.
- Reset mid-operation:
  - All state returns to reset values on the next edge, including while in ISSUE.
  - A pending instruction is dropped. It is not re-issued, and PC restarts at 0.

## Timing
- Datapath instruction sequence, with fetch at cycle t:
  - t: FETCH.
  - t+1: DECODE.
  - t+2: ISSUE with `instr_valid_o`=1. The EU accepts at the end of this cycle.
  - t+3: `instr_done_i`=1.
  - t+4: next FETCH.
- Throughput:
  - 4 cycles per datapath instruction.
  - 2 cycles per branch or NOP.
  - 2 cycles from HALT fetch to `halted_o`=1.
- `instr_valid_o` is registered and deasserts on the edge ending the `instr_done_i` cycle. This guarantees the EU, which is back in IDLE at t+4, never re-accepts the same instruction.
- A slow EU stretches ISSUE indefinitely; there is no timeout.
- IDLE/HALTED → FETCH is one cycle after `start_i`.

## Structure
- Shared package:
  - Opcode constants 0–15. The 0–11 values are shared with the decoder and EU controller and must match the EU state encodings.
  - IFU state encoding.
  - Instruction field positions.
- One sub-module: `ifu_pc`.
  - Holds the PC register with synchronous reset.
  - Selects among hold, +1, and +sign-extended 4-bit offset, with wrap-around.
  - It is built on the existing `dff` cell.
- Remaining logic is the FSM and the instruction register in `ifu`.

## Test plan
- Reset, then `start_i` pulse. Memory[0]=ADD (0x3_). Expect: `imem_rd_enb_o` at cycle 1; `instr_o`=0x30 with `instr_valid_o` at cycle 3; with `instr_done_i` at cycle 4, expect `instr_valid_o`=0 and PC=1 at cycle 5.
- Memory[5]=BRT −3 (0xCD), `cmp_flag_i`=1 → next fetch address 2. With `cmp_flag_i`=0 → next fetch address 6. `instr_valid_o` stays 0 throughout.
- PC=255 executing NOP → next `imem_addr_o`=0. PC=1 with BRF −4 and flag=0 → address 253.
- Memory[7]=HALT → `halted_o`=1 and `pc_o`=8. `start_i` → fetch at address 8 and `halted_o`=0.
- Hold `instr_done_i`=0 for 10 cycles in ISSUE → `instr_o` and `instr_valid_o` stable, PC unchanged. Assert `rst` mid-ISSUE → next cycle all outputs at reset values.
- Assert `start_i` during ISSUE, and assert `instr_done_i` during FETCH → no state or PC change.

Source files
------------

// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared opcodes, FSM encoding and field widths for the fetch unit
package ifu_pkg;

    localparam int OPC_W = 4;
    localparam int OFS_W = 4;

    // 0..11 must match the EU controller state encodings
    typedef enum logic [OPC_W-1:0] {
        OP_LOAD   = 4'd0,
        OP_AND    = 4'd1,
        OP_STORE  = 4'd2,
        OP_ADD    = 4'd3,
        OP_ADI    = 4'd4,
        OP_CMPLT  = 4'd5,
        OP_CMPEQ  = 4'd6,
        OP_CMPEQI = 4'd7,
        OP_SHFTR  = 4'd8,
        OP_SHFTL  = 4'd9,
        OP_INV    = 4'd10,
        OP_MVI    = 4'd11,
        OP_BRT    = 4'd12,
        OP_BRF    = 4'd13,
        OP_NOP    = 4'd14,
        OP_HALT   = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_HALTED = 3'd4
    } ifu_state_e;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_INC    = 2'd1,
        PC_BRANCH = 2'd2
    } pc_sel_e;

    function automatic logic is_datapath(input opcode_e opc);
        return (opc <= OP_MVI);
    endfunction

endpackage

// File: rtl/dff.sv
// rtl/dff.sv - generic register cell with synchronous active-high reset
module dff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_o <= RST_VAL;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/ifu_pc.sv
// rtl/ifu_pc.sv - program counter: hold, increment or relative branch, wrapping
module ifu_pc
    import ifu_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  pc_sel_e          sel_i,
    input  logic [OFS_W-1:0] ofs_i,
    output logic [PC_W-1:0]  pc_o
);

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] ofs_ext;

    // Offset is relative to the branch's own address; overflow wraps modulo 2^PC_W
    assign ofs_ext = {{(PC_W-OFS_W){ofs_i[OFS_W-1]}}, ofs_i};

    always_comb begin
        pc_d = pc_q;
        case (sel_i)
            PC_INC:    pc_d = pc_q + PC_ONE;
            PC_BRANCH: pc_d = pc_q + ofs_ext;
            default:   pc_d = pc_q;
        endcase
    end

    dff #(.W(PC_W)) u_pc_reg (
        .clk (clk),
        .rst (rst),
        .d_i (pc_d),
        .q_o (pc_q)
    );

    assign pc_o = pc_q;

endmodule

// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch unit: fetch/decode FSM and instruction register
module ifu
    import ifu_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    output logic               imem_rd_enb_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic               instr_valid_o,
    input  logic               instr_done_i,
    input  logic               cmp_flag_i,
    output logic               halted_o,
    output logic [PC_W-1:0]    pc_o
);

    ifu_state_e         state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    pc_sel_e            pc_sel;
    opcode_e            opc;
    logic [PC_W-1:0]    pc;

    assign opc = opcode_e'(imem_data_i[INSTR_W-1 -: OPC_W]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        valid_d = valid_q;
        pc_sel  = PC_HOLD;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_datapath(opc)) begin
                    instr_d = imem_data_i;
                    valid_d = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    // Control flow resolves here; PC still holds this instruction's address
                    state_d = S_FETCH;
                    pc_sel  = PC_INC;
                    case (opc)
                        OP_BRT:  if (cmp_flag_i)  pc_sel = PC_BRANCH;
                        OP_BRF:  if (!cmp_flag_i) pc_sel = PC_BRANCH;
                        OP_HALT: state_d = S_HALTED;
                        default: pc_sel = PC_INC;
                    endcase
                end
            end
            S_ISSUE: begin
                if (instr_done_i) begin
                    valid_d = 1'b0;
                    pc_sel  = PC_INC;
                    state_d = S_FETCH;
                end
            end
            S_HALTED: begin
                if (start_i) state_d = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    ifu_pc #(.PC_W(PC_W)) u_pc (
        .clk   (clk),
        .rst   (rst),
        .sel_i (pc_sel),
        .ofs_i (imem_data_i[OFS_W-1:0]),
        .pc_o  (pc)
    );

    assign imem_rd_enb_o = (state_q == S_FETCH);
    assign halted_o      = (state_q == S_HALTED);
    assign imem_addr_o   = pc;
    assign pc_o          = pc;
    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;

endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - scoreboard bench for the instruction fetch unit
module tb_ifu;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic       imem_rd_enb_o;
    logic [7:0] imem_addr_o;
    logic [7:0] imem_data_i;
    logic [7:0] instr_o;
    logic       instr_valid_o;
    logic       instr_done_i;
    logic       cmp_flag_i;
    logic       halted_o;
    logic [7:0] pc_o;

    logic [7:0] mem [256];
    logic [7:0] exp_fetch_q [$];
    logic [7:0] exp_issue_q [$];

    logic eu_auto;
    logic eu_done;
    logic man_done;
    int   issue_cnt;
    logic prev_valid;
    int   n_cmp;
    int   n_err;

    always #5 clk = ~clk;

    assign instr_done_i = eu_auto ? eu_done : man_done;

    ifu #(.PC_W(8), .INSTR_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .imem_rd_enb_o (imem_rd_enb_o),
        .imem_addr_o   (imem_addr_o),
        .imem_data_i   (imem_data_i),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o),
        .instr_done_i  (instr_done_i),
        .cmp_flag_i    (cmp_flag_i),
        .halted_o      (halted_o),
        .pc_o          (pc_o)
    );

    always @(posedge clk) begin
        if (imem_rd_enb_o) imem_data_i <= mem[imem_addr_o];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard pops on every fetch and every new issue; EU model answers one cycle after accept
    always @(negedge clk) begin
        if (imem_rd_enb_o) begin
            if (exp_fetch_q.size() == 0) check("fetch_unexpected", 32'(imem_addr_o), 32'hDEAD);
            else check("fetch_addr", 32'(imem_addr_o), 32'(exp_fetch_q.pop_front()));
        end
        if (instr_valid_o && !prev_valid) begin
            if (exp_issue_q.size() == 0) check("issue_unexpected", 32'(instr_o), 32'hDEAD);
            else check("issue_instr", 32'(instr_o), 32'(exp_issue_q.pop_front()));
        end
        eu_done    = instr_valid_o && (issue_cnt == 1);
        issue_cnt  = instr_valid_o ? issue_cnt + 1 : 0;
        prev_valid = instr_valid_o;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_fetch_q.delete();
        exp_issue_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"}, 32'(pc_o), 0);
        check({tag, "_addr"}, 32'(imem_addr_o), 0);
        check({tag, "_rd"}, 32'(imem_rd_enb_o), 0);
        check({tag, "_instr"}, 32'(instr_o), 0);
        check({tag, "_valid"}, 32'(instr_valid_o), 0);
        check({tag, "_halted"}, 32'(halted_o), 0);
    endtask

    task automatic wait_fetch(input logic [7:0] a, input string tag);
        int n = 0;
        while (!(imem_rd_enb_o && imem_addr_o == a) && n < 300) begin
            step();
            n++;
        end
        check(tag, 32'(imem_rd_enb_o && imem_addr_o == a), 1);
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (!halted_o && n < 300) begin
            step();
            n++;
        end
        check(tag, 32'(halted_o), 1);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_fetch_left"}, 32'(exp_fetch_q.size()), 0);
        check({tag, "_issue_left"}, 32'(exp_issue_q.size()), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1; start_i = 1'b0; man_done = 1'b0; eu_auto = 1'b1;
        cmp_flag_i = 1'b0; issue_cnt = 0; prev_valid = 1'b0; eu_done = 1'b0;
        imem_data_i = 8'h00;
        @(negedge clk);

        // ADD at 0: cycle-exact timing, then HALT at 1
        fill_mem();
        mem[0] = 8'h30;
        do_reset();
        check_reset_outputs("reset");
        step();
        exp_fetch_q = '{8'd0, 8'd1};
        exp_issue_q = '{8'h30};
        pulse_start();
        check("c1_rd", 32'(imem_rd_enb_o), 1);
        check("c1_addr", 32'(imem_addr_o), 0);
        step();
        check("c2_rd", 32'(imem_rd_enb_o), 0);
        check("c2_valid", 32'(instr_valid_o), 0);
        step();
        check("c3_valid", 32'(instr_valid_o), 1);
        check("c3_instr", 32'(instr_o), 32'h30);
        step();
        check("c4_valid", 32'(instr_valid_o), 1);
        step();
        check("c5_valid", 32'(instr_valid_o), 0);
        check("c5_pc", 32'(pc_o), 1);
        check("c5_rd", 32'(imem_rd_enb_o), 1);
        step();
        step();
        check("halt_2cyc", 32'(halted_o), 1);
        check("halt_pc", 32'(pc_o), 2);
        check_drained("t1");

        // BRT -3 at 5: taken goes to 2, not taken goes to 6
        fill_mem();
        for (int i = 0; i < 5; i++) mem[i] = 8'hE0;
        mem[5] = 8'hCD;
        do_reset();
        cmp_flag_i = 1'b1;
        exp_fetch_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
        pulse_start();
        wait_fetch(8'd5, "reach_5");
        step();
        step();
        check("brt_taken", 32'(imem_addr_o), 2);
        cmp_flag_i = 1'b0;
        wait_fetch(8'd5, "reach_5_again");
        step();
        step();
        check("brt_not_taken", 32'(imem_addr_o), 6);
        wait_halt("t2_halt");
        check("t2_pc", 32'(pc_o), 7);
        check_drained("t2");

        // BRF -4 at 1 wraps down to 253, NOP at 255 wraps up to 0
        fill_mem();
        mem[0] = 8'hE0; mem[1] = 8'hDC;
        mem[253] = 8'hE0; mem[254] = 8'hE0; mem[255] = 8'hE0;
        do_reset();
        cmp_flag_i = 1'b0;
        exp_fetch_q = '{8'd0, 8'd1, 8'd253, 8'd254, 8'd255, 8'd0, 8'd1, 8'd2};
        pulse_start();
        step(); step(); step(); step();
        check("brf_wrap_addr", 32'(imem_addr_o), 253);
        wait_fetch(8'd255, "reach_255");
        cmp_flag_i = 1'b1;
        step();
        step();
        check("inc_wrap_addr", 32'(imem_addr_o), 0);
        check("inc_wrap_rd", 32'(imem_rd_enb_o), 1);
        wait_halt("t3_halt");
        check("t3_pc", 32'(pc_o), 3);
        check_drained("t3");

        // HALT at 7 then resume at 8
        fill_mem();
        for (int i = 0; i < 7; i++) mem[i] = 8'hE0;
        mem[8] = 8'h4A;
        do_reset();
        exp_fetch_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        exp_issue_q = '{8'h4A};
        pulse_start();
        wait_halt("t4_halt");
        check("t4_halt_pc", 32'(pc_o), 8);
        step();
        check("t4_hold_halted", 32'(halted_o), 1);
        pulse_start();
        check("resume_rd", 32'(imem_rd_enb_o), 1);
        check("resume_addr", 32'(imem_addr_o), 8);
        check("resume_halted", 32'(halted_o), 0);
        wait_halt("t4_halt2");
        check("t4_pc2", 32'(pc_o), 10);
        check_drained("t4");

        // Slow EU, stray start/done, reset in ISSUE
        fill_mem();
        mem[0] = 8'h5B;
        do_reset();
        eu_auto = 1'b0;
        exp_fetch_q = '{8'd0};
        exp_issue_q = '{8'h5B};
        pulse_start();
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        check("done_in_fetch_rd", 32'(imem_rd_enb_o), 0);
        check("done_in_fetch_pc", 32'(pc_o), 0);
        step();
        check("issue_valid", 32'(instr_valid_o), 1);
        for (int i = 0; i < 10; i++) begin
            start_i = 1'b1;
            step();
            check("stall_instr", 32'(instr_o), 32'h5B);
            check("stall_valid", 32'(instr_valid_o), 1);
            check("stall_pc", 32'(pc_o), 0);
            check("stall_rd", 32'(imem_rd_enb_o), 0);
        end
        start_i = 1'b0;
        rst = 1'b1;
        step();
        check_reset_outputs("mid_issue_rst");
        rst = 1'b0;
        step();
        step();
        check("no_reissue_valid", 32'(instr_valid_o), 0);
        check("no_reissue_rd", 32'(imem_rd_enb_o), 0);
        check_drained("t5a");
        eu_auto = 1'b1;
        exp_fetch_q = '{8'd0, 8'd1};
        exp_issue_q = '{8'h5B};
        pulse_start();
        check("restart_addr", 32'(imem_addr_o), 0);
        wait_halt("t5_halt");
        check("t5_pc", 32'(pc_o), 2);
        check_drained("t5b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
